exponential_unit: RTL and testbench

Iterative single-precision exponential unit that computes Op_Q_95 = e^x for an IEEE-754 binary32 operand Op_X_95. It is the inverse companion of the team's logarithmic unit and shares its operand/result/Enable/Done/Error handshake, so the two units are interchangeable behind the same controller. Internally it runs a multicycle fixed-point datapath: range reduction, a Horner-form Taylor series, then normalisation and rounding.

---
 rtl/exponential_unit.sv | 209 ++++++++++++++++++++
 tb/tb_exponential_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/exponential_unit.sv
// Iterative binary32 e^x: reduce x to r = x - k*ln2, evaluate e^r with a Horner
// Taylor series in fixed point, then normalise/round with the exponent offset k.
module exponential_unit #(
  parameter int SERIES_TERMS = 10,
  parameter int FRAC_W       = 40
) (
  input  logic        clk_95,
  input  logic        reset_95,
  input  logic        Enable_95,
  input  logic [31:0] Op_X_95,
  output logic [31:0] Op_Q_95,
  output logic        Done_95,
  output logic        Error_95
);
  localparam int XW = FRAC_W + 8;   // unsigned |x|, 8 integer bits
  localparam int AW = FRAC_W + 3;   // signed acc and r
  localparam int CW = FRAC_W + 1;   // unsigned constants below 2.0
  localparam int PW = XW + CW;
  localparam int DW = XW + 2;
  localparam int MW = 2 * AW;
  localparam int NW = $clog2(SERIES_TERMS + 1);

  localparam logic [63:0] LN2_64      = 64'hB172_17F7_D1CF_79AB;
  localparam logic [63:0] INV_LN2_F64 = 64'h7154_7652_B82F_E177;
  localparam logic [CW-1:0] ONE_C     = CW'(1) << FRAC_W;
  localparam logic [CW-1:0] LN2_C     = CW'(LN2_64 >> (64 - FRAC_W));
  localparam logic [CW-1:0] INV_LN2_C = ONE_C | CW'(INV_LN2_F64 >> (64 - FRAC_W));
  localparam logic signed [AW-1:0] ONE_A = AW'(ONE_C);
  localparam logic [PW-1:0] K_HALF    = PW'(1) << (2 * FRAC_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REDUCE, S_SERIES, S_NORM, S_DONE} state_e;
  typedef enum logic [2:0] {C_NORMAL, C_NAN, C_POS_INF, C_NEG_INF, C_ZERO} cls_e;

  state_e               state_q, state_d;
  cls_e                 cls_q, cls_d;
  logic [31:0]          op_q, op_d, q_q, q_d;
  logic                 x_neg_q, x_neg_d, err_q, err_d, done_q, done_d;
  logic [XW-1:0]        x_mag_q, x_mag_d;
  logic signed [8:0]    k_q, k_d;
  logic signed [AW-1:0] r_q, r_d, acc_q, acc_d;
  logic [NW-1:0]        n_q, n_d;

  logic [CW-1:0] recip_rom [0:SERIES_TERMS];
  assign recip_rom[0] = '0;
  for (genvar g = 1; g <= SERIES_TERMS; g++) begin : g_recip
    assign recip_rom[g] = CW'((64'(ONE_C) + 64'(g / 2)) / 64'(g));
  end

  // Unpack: 1.m * 2^(e-150) scaled by 2^FRAC_W is a shift of the significand.
  cls_e          ld_cls;
  logic [XW-1:0] ld_mag;
  int            ld_sh;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    ld_cls = C_NORMAL;
    ld_mag = '0;
    ld_sh  = int'(op_q[30:23]) - (150 - FRAC_W);
    if (op_q[30:23] == 8'hFF)
      ld_cls = (op_q[22:0] != 23'd0) ? C_NAN : (op_q[31] ? C_NEG_INF : C_POS_INF);
    else if (op_q[30:23] == 8'h00)
      ld_cls = C_ZERO;
    else if (!op_q[31] && op_q[30:0] > 31'h42B1_7217)
      ld_cls = C_POS_INF;
    else if (op_q[30:23] >= 8'd134)
      ld_mag = XW'(1) << (FRAC_W + 7);  // x <= -128 saturates; result flushes to zero
    else if (ld_sh >= 0)
      ld_mag = XW'({1'b1, op_q[22:0]}) << ld_sh;
    else
      ld_mag = XW'({1'b1, op_q[22:0]}) >> (-ld_sh);
  end

  logic [PW-1:0]        rd_prod;
  logic [8:0]           rd_kmag;
  logic [DW-1:0]        rd_kln2;
  logic signed [DW-1:0] rd_rdiff;
  always_comb begin
    rd_prod  = PW'(x_mag_q) * PW'(INV_LN2_C);
    rd_kmag  = 9'((rd_prod + K_HALF) >> (2 * FRAC_W));
    rd_kln2  = DW'(rd_kmag) * DW'(LN2_C);
    rd_rdiff = $signed({2'b00, x_mag_q}) - $signed(rd_kln2);
  end

  logic signed [MW-1:0] sr_t1, sr_t2;
  logic signed [AW-1:0] sr_t1_tr, sr_acc;
  always_comb begin
    sr_t1    = MW'(acc_q) * MW'(r_q);
    sr_t1_tr = AW'(sr_t1 >>> FRAC_W);
    sr_t2    = MW'(sr_t1_tr) * MW'($signed({2'b00, recip_rom[n_q]}));
    sr_acc   = ONE_A + AW'(sr_t2 >>> FRAC_W);
  end

  // acc lies in [0.70, 1.42], so the leading one is at FRAC_W or FRAC_W-1.
  logic              nm_hi, nm_guard, nm_sticky, nm_up, nm_err;
  logic [FRAC_W-1:0] nm_frac;
  logic [23:0]       nm_sig;
  logic [24:0]       nm_rnd;
  logic [22:0]       nm_mant;
  logic [31:0]       nm_q;
  int                nm_exp;
  always_comb begin
    nm_hi     = acc_q[FRAC_W];
    nm_frac   = nm_hi ? acc_q[FRAC_W-1:0] : {acc_q[FRAC_W-2:0], 1'b0};
    nm_sig    = {1'b1, nm_frac[FRAC_W-1 -: 23]};
    nm_guard  = nm_frac[FRAC_W-24];
    nm_sticky = |nm_frac[FRAC_W-25:0];
    nm_up     = nm_guard & (nm_sticky | nm_sig[0]);
    nm_rnd    = {1'b0, nm_sig} + 25'(nm_up);
    nm_mant   = nm_rnd[24] ? nm_rnd[23:1] : nm_rnd[22:0];
    nm_exp    = 127 + int'(k_q) - (nm_hi ? 0 : 1) + (nm_rnd[24] ? 1 : 0);
    nm_err    = 1'b0;
    if (nm_exp < 1) begin
      nm_q = 32'h0000_0000;
    end else if (nm_exp > 254) begin
      nm_q   = 32'h7F80_0000;
      nm_err = 1'b1;
    end else begin
      nm_q = {1'b0, 8'(nm_exp), nm_mant};
    end
    unique case (cls_q)
      C_NAN:     begin nm_q = 32'h7FC0_0000; nm_err = 1'b1; end
      C_POS_INF: begin nm_q = 32'h7F80_0000; nm_err = 1'b1; end
      C_NEG_INF: begin nm_q = 32'h0000_0000; nm_err = 1'b0; end
      C_ZERO:    begin nm_q = 32'h3F80_0000; nm_err = 1'b0; end
      default:   ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    op_d    = op_q;
    x_neg_d = x_neg_q;
    x_mag_d = x_mag_q;
    k_d     = k_q;
    r_d     = r_q;
    acc_d   = acc_q;
    n_d     = n_q;
    q_d     = q_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: if (Enable_95) begin
        op_d    = Op_X_95;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        x_neg_d = op_q[31];
        x_mag_d = ld_mag;
        cls_d   = ld_cls;
        state_d = S_REDUCE;
      end
      S_REDUCE: begin
        k_d     = x_neg_q ? -$signed(rd_kmag) : $signed(rd_kmag);
        r_d     = AW'(x_neg_q ? -rd_rdiff : rd_rdiff);
        acc_d   = ONE_A;
        n_d     = NW'(SERIES_TERMS);
        state_d = S_SERIES;
      end
      S_SERIES: begin
        acc_d = sr_acc;
        n_d   = n_q - NW'(1);
        if (n_q == NW'(1)) state_d = S_NORM;
      end
      S_NORM: begin
        q_d     = nm_q;
        err_d   = nm_err;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_95 or negedge reset_95) begin
    if (!reset_95) begin
      state_q <= S_IDLE;
      cls_q   <= C_NORMAL;
      op_q    <= '0;
      x_neg_q <= 1'b0;
      x_mag_q <= '0;
      k_q     <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      n_q     <= '0;
      q_q     <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q <= state_d;
      cls_q   <= cls_d;
      op_q    <= op_d;
      x_neg_q <= x_neg_d;
      x_mag_q <= x_mag_d;
      k_q     <= k_d;
      r_q     <= r_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      q_q     <= q_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign Op_Q_95  = q_q;
  assign Error_95 = err_q;
  assign Done_95  = done_q;
endmodule

// File: tb/tb_exponential_unit.sv
// Directed bench for exponential_unit: a scoreboard queue holds expected results and
// Done cycles; a negedge monitor pops and checks them when Done_95 pulses.
module tb_exponential_unit;
  logic        clk_95 = 1'b0;
  logic        reset_95;
  logic        Enable_95;
  logic [31:0] Op_X_95;
  logic [31:0] Op_Q_95;
  logic        Done_95;
  logic        Error_95;

  exponential_unit dut (
    .clk_95   (clk_95),
    .reset_95 (reset_95),
    .Enable_95(Enable_95),
    .Op_X_95  (Op_X_95),
    .Op_Q_95  (Op_Q_95),
    .Done_95  (Done_95),
    .Error_95 (Error_95)
  );

  always #5 clk_95 = ~clk_95;

  typedef struct {
    logic [31:0] x;
    logic [31:0] q;
    logic        err;
    bit          ulp;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always @(posedge clk_95) cyc++;

  function automatic bit close(input logic [31:0] a, input logic [31:0] b, input bit ulp);
    logic [31:0] d;
    if (!ulp || $isunknown(a)) return a === b;
    d = (a > b) ? a - b : b - a;
    return d <= 32'd1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: the next rising edge is the accepting edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] q, input logic err, input bit ulp);
    Op_X_95   = x;
    Enable_95 = 1'b1;
    sb.push_back('{x: x, q: q, err: err, ulp: ulp, due: cyc + 14});
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk_95);
    n_cmp++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk_95);
  endtask

  always @(negedge clk_95) begin
    exp_t e;
    if (Done_95 === 1'b1) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_done: observed Done_95=1 at cycle %0d expected no pulse", cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        assert (close(Op_Q_95, e.q, e.ulp)) else begin
          n_fail++;
          $error("FAIL q_%h: observed %h expected %h", e.x, Op_Q_95, e.q);
        end
        n_cmp++;
        assert (Error_95 === e.err) else begin
          n_fail++;
          $error("FAIL err_%h: observed %b expected %b", e.x, Error_95, e.err);
        end
        n_cmp++;
        assert (cyc == e.due) else begin
          n_fail++;
          $error("FAIL latency_%h: observed done at %0d expected %0d", e.x, cyc, e.due);
        end
      end
    end
  end

  initial begin
    logic [31:0] spec_x [5];
    logic [31:0] spec_q [5];
    logic        spec_e [5];
    spec_x = '{32'h42B2_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'hC2C8_0000, 32'h0000_0001};
    spec_q = '{32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0000, 32'h0000_0000, 32'h3F80_0000};
    spec_e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    reset_95  = 1'b0;
    Enable_95 = 1'b0;
    Op_X_95   = 32'h0;
    repeat (3) @(negedge clk_95);
    check("reset_q", 64'(Op_Q_95), 64'h0);
    check("reset_done", 64'(Done_95), 64'h0);
    check("reset_err", 64'(Error_95), 64'h0);
    reset_95 = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk_95);
      check("idle_outputs", 64'({Op_Q_95, Done_95, Error_95}), 64'h0);
    end

    // e^1 with a one-cycle request.
    issue(32'h3F80_0000, 32'h402D_F854, 1'b0, 1'b1);
    @(negedge clk_95);
    Enable_95 = 1'b0;
    drain();

    // Back-to-back with Enable_95 held high: accepts every 15 cycles.
    issue(32'h0000_0000, 32'h3F80_0000, 1'b0, 1'b1);
    repeat (15) @(negedge clk_95);
    issue(32'hBF80_0000, 32'h3EBC_5AB2, 1'b0, 1'b1);
    repeat (15) @(negedge clk_95);
    issue(32'h4120_0000, 32'h46AC_14EE, 1'b0, 1'b1);
    @(negedge clk_95);
    Enable_95 = 1'b0;
    drain();

    for (int i = 0; i < 5; i++) begin
      issue(spec_x[i], spec_q[i], spec_e[i], 1'b0);
      @(negedge clk_95);
      Enable_95 = 1'b0;
      drain();
    end

    // A new request and operand during SERIES must be ignored.
    issue(32'h4000_0000, 32'h40EC_7326, 1'b0, 1'b1);
    @(negedge clk_95);
    Enable_95 = 1'b0;
    repeat (4) @(negedge clk_95);
    Op_X_95   = 32'hBF80_0000;
    Enable_95 = 1'b1;
    @(negedge clk_95);
    Enable_95 = 1'b0;
    Op_X_95   = 32'h1234_5678;
    drain();

    // Reset at edge 6 of an operation aborts it.
    issue(32'h3F80_0000, 32'h402D_F854, 1'b0, 1'b1);
    @(negedge clk_95);
    Enable_95 = 1'b0;
    repeat (6) @(posedge clk_95);
    #1 reset_95 = 1'b0;
    #1;
    sb.delete();
    check("abort_q", 64'(Op_Q_95), 64'h0);
    check("abort_done", 64'(Done_95), 64'h0);
    check("abort_err", 64'(Error_95), 64'h0);
    @(negedge clk_95);
    reset_95 = 1'b1;
    repeat (20) @(negedge clk_95);
    check("abort_hold_q", 64'(Op_Q_95), 64'h0);
    issue(32'h3F00_0000, 32'h3FD3_094C, 1'b0, 1'b1);
    @(negedge clk_95);
    Enable_95 = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish before 200000");
    $fatal(1);
  end
endmodule
